// File: rtl/sequenciador_palavras_pkg.sv
// Shared types for the word sequencer:
// note/type codes, FSM states, buffer entry.
package sequenciador_palavras_pkg;

  typedef enum logic [2:0] {
    NOTA_X   = 3'd0,
    NOTA_DO  = 3'd1,
    NOTA_RE  = 3'd2,
    NOTA_MI  = 3'd3,
    NOTA_FA  = 3'd4,
    NOTA_SOL = 3'd5,
    NOTA_LA  = 3'd6,
    NOTA_SI  = 3'd7
  } nota_t;

  typedef enum logic [1:0] {
    TIPO_NULO = 2'b00,
    TIPO_ADJ  = 2'b01,
    TIPO_COMP = 2'b10,
    TIPO_ADV  = 2'b11
  } tipo_t;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    CAPTURA   = 3'd1,
    ENVIA     = 3'd2,
    TERMINA   = 3'd3,
    ESPERA    = 3'd4,
    LIMPA     = 3'd5,
    RESULTADO = 3'd6
  } estado_t;

  typedef struct packed {
    logic       tom;
    logic [2:0] nota;
  } nota_buf_t;

  function automatic nota_buf_t empacota(
    input logic       tom,
    input logic [2:0] nota
  );
    nota_buf_t e;
    e.tom  = tom;
    e.nota = nota;
    return e;
  endfunction

endpackage

// File: rtl/sequenciador_palavras_if.sv
// Requester, classifier and result bundle
// of the word sequencer.
interface sequenciador_palavras_if;

  logic       req_a;
  logic       req_b;
  logic [2:0] nota_a;
  logic [2:0] nota_b;
  logic       tom_a;
  logic       tom_b;
  logic       ultima_a;
  logic       ultima_b;
  logic       ack_a;
  logic       ack_b;
  logic       cls_reset;
  logic       cls_ok;
  logic [2:0] cls_nota;
  logic       cls_tom;
  logic       cls_fim;
  logic [1:0] cls_tipo;
  logic       res_valido;
  logic [1:0] res_tipo;
  logic       res_dono;
  logic       res_erro;
  logic       ocupado;

  modport slave (
    input  req_a, req_b, nota_a, nota_b,
    input  tom_a, tom_b, ultima_a, ultima_b,
    input  cls_fim, cls_tipo,
    output ack_a, ack_b,
    output cls_reset, cls_ok, cls_nota, cls_tom,
    output res_valido, res_tipo, res_dono,
    output res_erro, ocupado
  );

  modport master (
    output req_a, req_b, nota_a, nota_b,
    output tom_a, tom_b, ultima_a, ultima_b,
    output cls_fim, cls_tipo,
    input  ack_a, ack_b,
    input  cls_reset, cls_ok, cls_nota, cls_tom,
    input  res_valido, res_tipo, res_dono,
    input  res_erro, ocupado
  );

endinterface

// File: rtl/sequenciador_palavras_arbitro.sv
// Two-requester round-robin arbiter; the
// grant is latched while load_i is high.
module arbitro_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic ptr_i,
  input  logic load_i,
  output logic dono_o
);

  logic dono_q;
  logic dono_d;

  // Pick the sole requester, or the pointer on a tie
  always_comb begin
    dono_d = dono_q;
    if (load_i) begin
      unique case ({req_a_i, req_b_i})
        2'b11:   dono_d = ptr_i;
        2'b10:   dono_d = 1'b0;
        2'b01:   dono_d = 1'b1;
        default: dono_d = dono_q;
      endcase
    end
  end

  // Grant register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dono_q <= 1'b0;
    else       dono_q <= dono_d;
  end

  assign dono_o = dono_q;

endmodule

// File: rtl/sequenciador_palavras.sv
// Shares one note classifier between two
// requesters, one buffered word at a time.
module sequenciador_palavras
  import sequenciador_palavras_pkg::*;
#(
  parameter int MAX_NOTAS = 4,
  parameter int TIMEOUT   = 15
) (
  input logic                    clk,
  input logic                    reset,
  sequenciador_palavras_if.slave bus
);

  localparam int AW =
    (MAX_NOTAS > 1) ? $clog2(MAX_NOTAS) : 1;
  localparam int CW = $clog2(MAX_NOTAS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  estado_t        est_q, est_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           fecha_q, fecha_d;
  logic           rr_q, rr_d;
  tipo_t          tipo_q, tipo_d;
  logic           erro_q, erro_d;
  logic           grava;
  nota_buf_t      mem_q [MAX_NOTAS];

  logic           ack_a_q, ack_a_d;
  logic           ack_b_q, ack_b_d;
  logic           cls_reset_q, cls_reset_d;
  logic           cls_ok_q, cls_ok_d;
  logic [2:0]     cls_nota_q, cls_nota_d;
  logic           cls_tom_q, cls_tom_d;
  logic           res_valido_q, res_valido_d;
  logic [1:0]     res_tipo_q, res_tipo_d;
  logic           res_dono_q, res_dono_d;
  logic           res_erro_q, res_erro_d;
  logic           ocupado_q, ocupado_d;

  logic           dono;
  logic           req_sel;
  logic           ack_sel;
  logic           ult_sel;
  logic           tom_sel;
  logic [2:0]     nota_sel;
  nota_buf_t      saida;

  arbitro_rr2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_a_i (bus.req_a),
    .req_b_i (bus.req_b),
    .ptr_i   (rr_q),
    .load_i  (est_q == OCIOSO),
    .dono_o  (dono)
  );

  assign req_sel  = dono ? bus.req_b    : bus.req_a;
  assign ack_sel  = dono ? ack_b_q      : ack_a_q;
  assign ult_sel  = dono ? bus.ultima_b : bus.ultima_a;
  assign tom_sel  = dono ? bus.tom_b    : bus.tom_a;
  assign nota_sel = dono ? bus.nota_b   : bus.nota_a;
  assign saida    = mem_q[idx_q];

  // Next state, counters and word capture
  always_comb begin
    est_d   = est_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    fecha_d = fecha_q;
    rr_d    = rr_q;
    tipo_d  = tipo_q;
    erro_d  = erro_q;
    grava   = 1'b0;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    unique case (est_q)
      OCIOSO: begin
        cnt_d   = '0;
        fecha_d = 1'b0;
        if (bus.req_a || bus.req_b)
          est_d = CAPTURA;
      end
      CAPTURA: begin
        if (fecha_q) begin
          est_d = ENVIA;
          idx_d = '0;
        end else if (req_sel && !ack_sel) begin
          grava   = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          ack_a_d = !dono;
          ack_b_d = dono;
          if (ult_sel ||
              cnt_q == CW'(MAX_NOTAS - 1))
            fecha_d = 1'b1;
        end
      end
      ENVIA: begin
        idx_d = idx_q + AW'(1);
        if (CW'(idx_q) == cnt_q - CW'(1))
          est_d = TERMINA;
      end
      TERMINA: begin
        wait_d = '0;
        est_d  = ESPERA;
      end
      ESPERA: begin
        if (bus.cls_fim) begin
          tipo_d = tipo_t'(bus.cls_tipo);
          erro_d = 1'b0;
          est_d  = LIMPA;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          tipo_d = TIPO_NULO;
          erro_d = 1'b1;
          est_d  = LIMPA;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      LIMPA: est_d = RESULTADO;
      RESULTADO: begin
        rr_d    = !dono;
        cnt_d   = '0;
        fecha_d = 1'b0;
        est_d   = OCIOSO;
      end
      default: est_d = OCIOSO;
    endcase
  end

  // Registered outputs follow the current state
  always_comb begin
    cls_reset_d  = (est_q == LIMPA);
    cls_ok_d     = (est_q == ENVIA) ||
                   (est_q == TERMINA);
    cls_nota_d   = NOTA_X;
    cls_tom_d    = 1'b0;
    res_valido_d = (est_q == RESULTADO);
    res_tipo_d   = res_tipo_q;
    res_dono_d   = res_dono_q;
    res_erro_d   = res_erro_q;
    ocupado_d    = (est_q != OCIOSO);
    if (est_q == ENVIA) begin
      cls_nota_d = saida.nota;
      cls_tom_d  = saida.tom;
    end
    if (est_q == RESULTADO) begin
      res_tipo_d = tipo_q;
      res_dono_d = dono;
      res_erro_d = erro_q;
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      est_q        <= OCIOSO;
      cnt_q        <= '0;
      idx_q        <= '0;
      wait_q       <= '0;
      fecha_q      <= 1'b0;
      rr_q         <= 1'b0;
      tipo_q       <= TIPO_NULO;
      erro_q       <= 1'b0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      cls_reset_q  <= 1'b1;
      cls_ok_q     <= 1'b0;
      cls_nota_q   <= '0;
      cls_tom_q    <= 1'b0;
      res_valido_q <= 1'b0;
      res_tipo_q   <= '0;
      res_dono_q   <= 1'b0;
      res_erro_q   <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      est_q        <= est_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wait_q       <= wait_d;
      fecha_q      <= fecha_d;
      rr_q         <= rr_d;
      tipo_q       <= tipo_d;
      erro_q       <= erro_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      cls_reset_q  <= cls_reset_d;
      cls_ok_q     <= cls_ok_d;
      cls_nota_q   <= cls_nota_d;
      cls_tom_q    <= cls_tom_d;
      res_valido_q <= res_valido_d;
      res_tipo_q   <= res_tipo_d;
      res_dono_q   <= res_dono_d;
      res_erro_q   <= res_erro_d;
      ocupado_q    <= ocupado_d;
    end
  end

  // Word buffer, written only on acceptance
  always_ff @(posedge clk) begin
    if (grava)
      mem_q[cnt_q[AW-1:0]] <=
        empacota(tom_sel, nota_sel);
  end

  assign bus.ack_a      = ack_a_q;
  assign bus.ack_b      = ack_b_q;
  assign bus.cls_reset  = cls_reset_q;
  assign bus.cls_ok     = cls_ok_q;
  assign bus.cls_nota   = cls_nota_q;
  assign bus.cls_tom    = cls_tom_q;
  assign bus.res_valido = res_valido_q;
  assign bus.res_tipo   = res_tipo_q;
  assign bus.res_dono   = res_dono_q;
  assign bus.res_erro   = res_erro_q;
  assign bus.ocupado    = ocupado_q;

endmodule

// File: tb/tb_sequenciador_palavras.sv
// Bench for the word sequencer: stand-in
// classifier, requesters and a word scoreboard.
module tb_sequenciador_palavras;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic        dono;
    logic        to;
    logic [2:0]  n;
    logic [15:0] nt;
  } palavra_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   res_cnt = 0;
  bit   fim_tie = 1'b0;

  palavra_t sb[$];

  int   pos = 0;
  int   ok_cyc = 0;
  int   term_cyc = 0;
  int   ack_cyc = 0;
  int   rst_cyc = 0;
  int   rst_seen = 0;

  int          hn = 0;
  logic [15:0] hist = '0;

  sequenciador_palavras_if bus ();

  sequenciador_palavras #(
    .MAX_NOTAS (4),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pk(
    input logic [3:0] n0, input logic [3:0] n1,
    input logic [3:0] n2, input logic [3:0] n3
  );
    return {n3, n2, n1, n0};
  endfunction

  // Classification rules of the stand-in classifier
  function automatic logic [1:0] tabela(
    input int n, input logic [15:0] s
  );
    if (n == 3 && s[2:0] == 3'd2 &&
        s[6:4] == 3'd3 && s[10:8] == 3'd6)
      return 2'b01;
    if (n == 4 && s[2:0] == 3'd1 &&
        s[6:4] == 3'd2 && s[10:8] == 3'd6 &&
        s[14:12] == 3'd1)
      return 2'b10;
    if (n == 4 && s[2:0] == 3'd4 &&
        s[6:4] == 3'd5 && s[10:8] == 3'd6 &&
        s[14:12] == 3'd7)
      return 2'b11;
    return 2'b00;
  endfunction

  // Stand-in classifier: nota_x ends the word
  always @(negedge clk) begin
    if (reset || bus.cls_reset) begin
      hn = 0;
      hist = '0;
      bus.cls_fim = 1'b0;
      bus.cls_tipo = 2'b00;
    end else if (bus.cls_ok && !bus.cls_fim) begin
      if (bus.cls_nota == 3'd0) begin
        if (!fim_tie) begin
          bus.cls_fim = 1'b1;
          bus.cls_tipo = tabela(hn, hist);
        end
      end else if (hn < 4) begin
        hist[4*hn +: 4] = {bus.cls_tom, bus.cls_nota};
        hn++;
      end
    end
  end

  // Compare process against the word scoreboard
  always @(negedge clk) begin
    palavra_t p;
    logic [3:0] e;
    int lat;
    if (reset) begin
      pos = 0;
      rst_seen = 0;
    end else begin
      if (bus.ack_a || bus.ack_b) begin
        chk("ack_sem_palavra", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          p = sb[0];
          chk("ack_dono", {30'd0, bus.ack_a, bus.ack_b},
              p.dono ? 32'd1 : 32'd2);
        end
        ack_cyc = cyc;
      end
      if (bus.cls_ok && sb.size() > 0) begin
        p = sb[0];
        if (pos > 0) chk("cls_ok_gap", 32'(cyc - ok_cyc), 1);
        chk("cls_ok_extra", 32'(pos <= int'(p.n)), 1);
        e = (pos < int'(p.n)) ? p.nt[4*pos +: 4] : 4'd0;
        chk("cls_nota", {28'd0, bus.cls_tom, bus.cls_nota},
            {28'd0, e});
        if (pos == int'(p.n)) begin
          term_cyc = cyc;
          rst_seen = 0;
        end
        pos++;
        ok_cyc = cyc;
      end
      if (bus.cls_reset && sb.size() > 0 &&
          pos > int'(sb[0].n)) begin
        rst_seen++;
        rst_cyc = cyc;
      end
      if (bus.res_valido) begin
        chk("res_sem_palavra", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          p = sb.pop_front();
          lat = p.to ? TIMEOUT : 1;
          chk("res_tipo", 32'(bus.res_tipo),
              p.to ? 32'd0 : 32'(tabela(int'(p.n), p.nt)));
          chk("res_dono", 32'(bus.res_dono), 32'(p.dono));
          chk("res_erro", 32'(bus.res_erro), 32'(p.to));
          chk("lat_term", 32'(cyc - term_cyc), 32'(lat + 2));
          chk("lat_ack", 32'(cyc - ack_cyc),
              32'(int'(p.n) + 4 + lat));
          chk("cls_reset_n", 32'(rst_seen), 1);
          chk("cls_reset_pos", 32'(cyc - rst_cyc), 1);
          chk("ocupado_res", 32'(bus.ocupado), 1);
        end
        pos = 0;
        res_cnt++;
      end
    end
  end

  task automatic envia(
    input bit          b,
    input int          n,
    input logic [15:0] nt,
    input bit          ult
  );
    int k;
    logic [3:0] x;
    for (int i = 0; i < n; i++) begin
      x = nt[4*i +: 4];
      if (b) begin
        bus.req_b = 1'b1;
        bus.nota_b = x[2:0];
        bus.tom_b = x[3];
        bus.ultima_b = ult && (i == n - 1);
      end else begin
        bus.req_a = 1'b1;
        bus.nota_a = x[2:0];
        bus.tom_a = x[3];
        bus.ultima_a = ult && (i == n - 1);
      end
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(b ? bus.ack_b : bus.ack_a) && k < 300);
      if (k >= 300) chk("ack_timeout", 32'(k), 0);
    end
    if (b) begin
      bus.req_b = 1'b0;
      bus.ultima_b = 1'b0;
    end else begin
      bus.req_a = 1'b0;
      bus.ultima_a = 1'b0;
    end
  endtask

  task automatic espera_res(input int alvo);
    int k;
    k = 0;
    while (res_cnt < alvo && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (res_cnt < alvo) chk("res_timeout", 32'(res_cnt), 32'(alvo));
    @(negedge clk);
  endtask

  task automatic pulsa_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
  endtask

  function automatic palavra_t pal(
    input bit d, input bit t, input int n,
    input logic [15:0] nt
  );
    palavra_t p;
    p.dono = d;
    p.to = t;
    p.n = 3'(n);
    p.nt = nt;
    return p;
  endfunction

  initial begin
    logic [15:0] w_adj, w_comp, w_adv;
    int okc, k;
    w_adj  = pk(4'd2, 4'd3, 4'd6, 4'd0);
    w_comp = pk(4'd1, 4'd2, 4'd6, 4'b1001);
    w_adv  = pk(4'd4, 4'd5, 4'd6, 4'd7);
    bus.req_a = 0; bus.req_b = 0;
    bus.nota_a = 0; bus.nota_b = 0;
    bus.tom_a = 0; bus.tom_b = 0;
    bus.ultima_a = 0; bus.ultima_b = 0;
    bus.cls_fim = 0; bus.cls_tipo = 0;

    repeat (3) @(negedge clk);
    chk("rst_cls_reset", 32'(bus.cls_reset), 1);
    chk("rst_cls_ok", 32'(bus.cls_ok), 0);
    chk("rst_ack", {30'd0, bus.ack_a, bus.ack_b}, 0);
    chk("rst_res", {29'd0, bus.res_valido, bus.res_tipo}, 0);
    chk("rst_ocupado", 32'(bus.ocupado), 0);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("cls_reset_off", 32'(bus.cls_reset), 0);

    sb.push_back(pal(0, 0, 3, w_adj));
    envia(0, 3, w_adj, 1);
    espera_res(1);
    chk("lit_adj_tipo", 32'(bus.res_tipo), 32'h1);
    chk("lit_adj_dono", 32'(bus.res_dono), 0);
    chk("lit_adj_erro", 32'(bus.res_erro), 0);
    chk("ocioso", 32'(bus.ocupado), 0);

    sb.push_back(pal(1, 0, 4, w_comp));
    envia(1, 4, w_comp, 0);
    espera_res(2);
    chk("lit_comp_tipo", 32'(bus.res_tipo), 32'h2);
    chk("lit_comp_dono", 32'(bus.res_dono), 1);

    sb.push_back(pal(0, 0, 4, w_adv));
    envia(0, 4, w_adv, 1);
    espera_res(3);
    chk("lit_adv_tipo", 32'(bus.res_tipo), 32'h3);

    fim_tie = 1'b1;
    sb.push_back(pal(0, 1, 3, w_adj));
    envia(0, 3, w_adj, 1);
    espera_res(4);
    chk("lit_to_tipo", 32'(bus.res_tipo), 0);
    chk("lit_to_erro", 32'(bus.res_erro), 1);
    fim_tie = 1'b0;

    sb.push_back(pal(0, 0, 3, pk(4'd1, 4'd2, 4'd3, 4'd0)));
    envia(0, 3, pk(4'd1, 4'd2, 4'd3, 4'd0), 1);
    okc = 0;
    k = 0;
    while (okc < 2 && k < 50) begin
      @(negedge clk);
      if (bus.cls_ok) okc++;
      k++;
    end
    chk("env_ok_seen", 32'(okc), 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_cls_ok", 32'(bus.cls_ok), 0);
    chk("arst_cls_reset", 32'(bus.cls_reset), 1);
    chk("arst_ocupado", 32'(bus.ocupado), 0);
    sb.delete();
    @(negedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pos_rst_ocioso", 32'(bus.ocupado), 0);
    chk("pos_rst_cls_reset", 32'(bus.cls_reset), 0);
    k = res_cnt;
    sb.push_back(pal(1, 0, 3, w_adj));
    envia(1, 3, w_adj, 1);
    espera_res(k + 1);
    chk("lit_pos_rst_tipo", 32'(bus.res_tipo), 32'h1);
    chk("lit_pos_rst_dono", 32'(bus.res_dono), 1);

    pulsa_reset();
    k = res_cnt;
    sb.push_back(pal(0, 0, 3, w_adj));
    sb.push_back(pal(1, 0, 4, w_comp));
    sb.push_back(pal(0, 0, 4, w_adv));
    fork
      begin
        envia(0, 3, w_adj, 1);
        envia(0, 4, w_adv, 1);
      end
      envia(1, 4, w_comp, 0);
    join
    espera_res(k + 3);
    chk("sim_todos", 32'(sb.size()), 0);
    chk("lit_sim_dono", 32'(bus.res_dono), 0);
    chk("lit_sim_tipo", 32'(bus.res_tipo), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
